capture_trig_ctrl: RTL and testbench

//  Downstream consumer of the protocol trigger output. Qualifies protTrig with the channel trigger,
//  and sequences sample capture into the circular sample RAM: pre-trigger fill, arm, trigger, post-fill.

---
 rtl/la_pkg.sv | 15 +
 rtl/capture_trig_ctrl_if.sv | 29 ++
 rtl/capture_trig_ctrl_addr_cnt.sv | 25 ++
 rtl/capture_trig_ctrl.sv | 157 +++++++++++++++
 tb/tb_capture_trig_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// Shared types and defaults for the logic-analyser capture path.
package la_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } cap_state_t;

    localparam int unsigned ENTRIES_DEF = 384;
    localparam int unsigned ADDR_W_DEF  = 9;

endpackage

// File: rtl/capture_trig_ctrl_if.sv
// Host/decimator/trigger signals into the capture controller and RAM-side results out.
interface capture_trig_ctrl_if #(
    parameter int unsigned ADDR_W = 9
) ();

    logic              run;
    logic              clr_done;
    logic              wrt_smpl;
    logic              protTrig;
    logic              chTrig;
    logic [ADDR_W-1:0] trig_pos;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] trig_addr;
    logic              armed;
    logic              triggered;
    logic              capture_done;

    modport master (
        output run, clr_done, wrt_smpl, protTrig, chTrig, trig_pos,
        input  we, waddr, trig_addr, armed, triggered, capture_done
    );

    modport slave (
        input  run, clr_done, wrt_smpl, protTrig, chTrig, trig_pos,
        output we, waddr, trig_addr, armed, triggered, capture_done
    );

endinterface

// File: rtl/capture_trig_ctrl_addr_cnt.sv
// Sample RAM write-address counter; wraps from ENTRIES-1 back to 0.
module capture_addr_cnt #(
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (inc) begin
            addr <= (addr == LAST) ? '0 : addr + 1'b1;
        end
    end

endmodule

// File: rtl/capture_trig_ctrl.sv
// Capture sequencer: pre-trigger fill, arm, qualified trigger, post-fill, sticky done.
module capture_trig_ctrl
    import la_pkg::*;
#(
    parameter int unsigned ENTRIES = ENTRIES_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input logic                clk,
    input logic                rst_n,
    capture_trig_ctrl_if.slave bus
);

    // One extra bit so a count can reach ENTRIES even when ENTRIES == 2**ADDR_W.
    localparam int unsigned        CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0]   ENTRIES_C = CNT_W'(ENTRIES);
    localparam logic [CNT_W-1:0]   ONE_C     = CNT_W'(1);

    cap_state_t        state_q, state_d;
    logic [CNT_W-1:0]  smpl_cnt_q, smpl_cnt_d;
    logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              armed_q, armed_d;
    logic              triggered_q, triggered_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  trig_pos_w, tp, pre;
    logic [ADDR_W-1:0] addr;
    logic              addr_clr, we, trig, active;

    always_comb begin
        trig_pos_w = CNT_W'(bus.trig_pos);
        if (trig_pos_w == '0) begin
            tp = ONE_C;
        end else if (trig_pos_w > ENTRIES_C) begin
            tp = ENTRIES_C;
        end else begin
            tp = trig_pos_w;
        end
        pre = ENTRIES_C - tp;
    end

    assign trig   = bus.protTrig & bus.chTrig;
    assign active = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
    assign we     = bus.wrt_smpl & bus.run & active;

    capture_addr_cnt #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W)
    ) u_addr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (addr_clr),
        .inc   (we),
        .addr  (addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            smpl_cnt_q  <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            smpl_cnt_q  <= smpl_cnt_d;
            post_cnt_q  <= post_cnt_d;
            trig_addr_q <= trig_addr_d;
            armed_q     <= armed_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        smpl_cnt_d  = smpl_cnt_q;
        post_cnt_d  = post_cnt_q;
        trig_addr_d = trig_addr_q;
        armed_d     = armed_q;
        triggered_d = triggered_q;
        done_d      = done_q;
        addr_clr    = 1'b0;

        if (bus.clr_done) begin
            done_d = 1'b0;
        end

        if (!bus.run) begin
            state_d     = IDLE;
            armed_d     = 1'b0;
            triggered_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!done_q) begin
                        state_d    = PRE;
                        addr_clr   = 1'b1;
                        smpl_cnt_d = '0;
                        post_cnt_d = '0;
                    end
                end
                PRE: begin
                    if (we && smpl_cnt_q != ENTRIES_C) begin
                        smpl_cnt_d = smpl_cnt_q + ONE_C;
                    end
                    // Arm on the write that completes the pre-fill, not a cycle later.
                    if (smpl_cnt_d >= pre) begin
                        state_d = ARMED;
                        armed_d = 1'b1;
                    end
                end
                ARMED: begin
                    if (we && trig) begin
                        trig_addr_d = addr;
                        triggered_d = 1'b1;
                        post_cnt_d  = ONE_C;
                        if (tp == ONE_C) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = POST;
                        end
                    end
                end
                POST: begin
                    if (we) begin
                        post_cnt_d = post_cnt_q + ONE_C;
                        // >= keeps the capture finite if trig_pos shrinks mid-capture.
                        if (post_cnt_d >= tp) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.clr_done) begin
                        state_d     = IDLE;
                        armed_d     = 1'b0;
                        triggered_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.we           = we;
    assign bus.waddr        = addr;
    assign bus.trig_addr    = trig_addr_q;
    assign bus.armed        = armed_q;
    assign bus.triggered    = triggered_q;
    assign bus.capture_done = done_q;

endmodule

// File: tb/tb_capture_trig_ctrl.sv
// Directed bench for capture_trig_ctrl with ENTRIES=8, ADDR_W=4.
module tb_capture_trig_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   we_cnt;
    logic last_we;
    logic [3:0] last_waddr;

    capture_trig_ctrl_if #(.ADDR_W(4)) bus ();

    capture_trig_ctrl #(
        .ENTRIES (8),
        .ADDR_W  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Called at a negedge: apply wrt_smpl, sample the combinational write, run one clock.
    task automatic step(input logic ws);
        bus.wrt_smpl = ws;
        #1;
        last_we = bus.we;
        if (bus.we) begin
            we_cnt++;
            last_waddr = bus.waddr;
        end
        @(negedge clk);
    endtask

    task automatic clear_done();
        bus.clr_done = 1'b1;
        step(1'b0);
        bus.clr_done = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        we_cnt     = 0;
        last_we    = 1'b0;
        last_waddr = '0;
        rst_n        = 1'b0;
        bus.run      = 1'b0;
        bus.clr_done = 1'b0;
        bus.wrt_smpl = 1'b0;
        bus.protTrig = 1'b0;
        bus.chTrig   = 1'b0;
        bus.trig_pos = '0;
        #1;
        check("rst_we", int'(bus.we), 0);
        check("rst_waddr", int'(bus.waddr), 0);
        check("rst_trig_addr", int'(bus.trig_addr), 0);
        check("rst_armed", int'(bus.armed), 0);
        check("rst_triggered", int'(bus.triggered), 0);
        check("rst_done", int'(bus.capture_done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: trig_pos=3, trigger always true, write every cycle
        bus.trig_pos = 4'd3;
        bus.protTrig = 1'b1;
        bus.chTrig   = 1'b1;
        bus.run      = 1'b1;
        step(1'b0);
        for (int i = 1; i <= 12; i++) begin
            step(1'b1);
            if (i == 4) check("t1_armed_w4", int'(bus.armed), 0);
            if (i == 5) check("t1_armed_w5", int'(bus.armed), 1);
            if (i == 7) check("t1_done_w7", int'(bus.capture_done), 0);
            if (i == 8) check("t1_done_w8", int'(bus.capture_done), 1);
        end
        check("t1_trig_addr", int'(bus.trig_addr), 5);
        check("t1_triggered", int'(bus.triggered), 1);
        check("t1_we_count", we_cnt, 8);
        check("t1_last_waddr", int'(last_waddr), 7);
        check("t1_waddr_wrap", int'(bus.waddr), 0);

        // 6a: done held with run=1 blocks writes until clr_done
        for (int i = 0; i < 3; i++) step(1'b1);
        check("t6_no_restart", we_cnt, 8);
        clear_done();
        check("t6_done_clr", int'(bus.capture_done), 0);
        check("t6_armed_clr", int'(bus.armed), 0);

        // 2: trigger only during pre-fill writes -> never triggers, address keeps wrapping
        we_cnt = 0;
        step(1'b0);
        for (int i = 1; i <= 20; i++) begin
            bus.protTrig = (i <= 4);
            step(1'b1);
        end
        check("t2_armed", int'(bus.armed), 1);
        check("t2_triggered", int'(bus.triggered), 0);
        check("t2_done", int'(bus.capture_done), 0);
        check("t2_we_count", we_cnt, 20);
        check("t2_waddr", int'(bus.waddr), 4);
        bus.run = 1'b0;
        step(1'b0);
        check("t2_abort_armed", int'(bus.armed), 0);

        // 3: channel trigger gates the protocol trigger
        bus.protTrig = 1'b1;
        bus.chTrig   = 1'b0;
        bus.run      = 1'b1;
        step(1'b0);
        for (int i = 1; i <= 16; i++) begin
            bus.chTrig = (i >= 11);
            step(1'b1);
            if (i == 10) check("t3_trig_w10", int'(bus.triggered), 0);
            if (i == 12) check("t3_done_w12", int'(bus.capture_done), 0);
            if (i == 13) check("t3_done_w13", int'(bus.capture_done), 1);
        end
        check("t3_trig_addr", int'(bus.trig_addr), 2);
        clear_done();

        // 4a: trig_pos=0 clamps to 1, done on the triggering write
        we_cnt = 0;
        bus.trig_pos = 4'd0;
        step(1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1);
            if (i == 7) check("t4a_done_w7", int'(bus.capture_done), 0);
            if (i == 8) check("t4a_done_w8", int'(bus.capture_done), 1);
        end
        check("t4a_trig_addr", int'(bus.trig_addr), 7);
        check("t4a_we_count", we_cnt, 8);
        clear_done();

        // 4b: trig_pos beyond ENTRIES (15 is the largest 4-bit value) clamps to 8
        we_cnt = 0;
        bus.trig_pos = 4'd15;
        step(1'b0);
        step(1'b0);
        check("t4b_armed_early", int'(bus.armed), 1);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1);
            if (i == 7) check("t4b_done_w7", int'(bus.capture_done), 0);
            if (i == 8) check("t4b_done_w8", int'(bus.capture_done), 1);
        end
        check("t4b_trig_addr", int'(bus.trig_addr), 0);
        check("t4b_we_count", we_cnt, 8);
        clear_done();

        // 5: run dropped during POST
        bus.trig_pos = 4'd3;
        step(1'b0);
        for (int i = 1; i <= 6; i++) step(1'b1);
        check("t5_triggered", int'(bus.triggered), 1);
        check("t5_waddr_post", int'(bus.waddr), 6);
        bus.run = 1'b0;
        step(1'b1);
        check("t5_abort_we", int'(last_we), 0);
        check("t5_abort_trig", int'(bus.triggered), 0);
        check("t5_abort_done", int'(bus.capture_done), 0);
        check("t5_abort_waddr", int'(bus.waddr), 6);
        bus.run = 1'b1;
        step(1'b0);
        check("t5_restart_waddr", int'(bus.waddr), 0);

        // 6b: asynchronous reset mid-POST
        for (int i = 1; i <= 6; i++) step(1'b1);
        check("t6_trig_addr_pre_rst", int'(bus.trig_addr), 5);
        bus.wrt_smpl = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_we", int'(bus.we), 0);
        check("t6_rst_waddr", int'(bus.waddr), 0);
        check("t6_rst_trig_addr", int'(bus.trig_addr), 0);
        check("t6_rst_armed", int'(bus.armed), 0);
        check("t6_rst_triggered", int'(bus.triggered), 0);
        check("t6_rst_done", int'(bus.capture_done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
